val2_shift_sequencer: RTL and testbench



---
 rtl/arm_shift_pkg.sv | 30 +++
 rtl/val2_shift_sequencer_shift_step.sv | 59 +++++
 rtl/val2_shift_sequencer.sv | 155 +++++++++++++++
 tb/tb_val2_shift_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_shift_pkg.sv
// Shared definitions for the Val2 shift sequencer: ARM shift-type codes,
// the internal step opcode set (adds ROR2 for immediates), FSM state
// encoding and fixed datapath widths.
package arm_shift_pkg;

   localparam int DATA_W = 32;
   localparam int SHOP_W = 12;

   // ARM shift-type field encodings (instruction bits [6:5])
   localparam logic [1:0] LSL = 2'b00;
   localparam logic [1:0] LSR = 2'b01;
   localparam logic [1:0] ASR = 2'b10;
   localparam logic [1:0] ROR = 2'b11;

   // One-step operations; ROR2 serves the rotated-immediate form
   typedef enum logic [2:0] {
      OP_LSL  = 3'd0,
      OP_LSR  = 3'd1,
      OP_ASR  = 3'd2,
      OP_ROR  = 3'd3,
      OP_ROR2 = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/val2_shift_sequencer_shift_step.sv
// shift_step: purely combinational single step of the Val2 shifter.
// With SHIFTER_CARRY_EN defined it also produces the bit shifted out.
module shift_step
   import arm_shift_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  op_e               op_i,
`ifdef SHIFTER_CARRY_EN
   input  logic              carry_i,
   output logic              carry_o,
`endif
   output logic [DATA_W-1:0] data_o
);

   // One shift/rotate step; carry is the bit leaving the word
   always_comb begin
      data_o = data_i;
`ifdef SHIFTER_CARRY_EN
      carry_o = carry_i;
`endif
      case (op_i)
         OP_LSL: begin
            data_o = {data_i[DATA_W-2:0], 1'b0};
`ifdef SHIFTER_CARRY_EN
            carry_o = data_i[DATA_W-1];
`endif
         end
         OP_LSR: begin
            data_o = {1'b0, data_i[DATA_W-1:1]};
`ifdef SHIFTER_CARRY_EN
            carry_o = data_i[0];
`endif
         end
         OP_ASR: begin
            data_o = {data_i[DATA_W-1], data_i[DATA_W-1:1]};
`ifdef SHIFTER_CARRY_EN
            carry_o = data_i[0];
`endif
         end
         OP_ROR: begin
            data_o = {data_i[0], data_i[DATA_W-1:1]};
`ifdef SHIFTER_CARRY_EN
            carry_o = data_i[0];
`endif
         end
         OP_ROR2: begin
            // Result bit 31 is the last bit rotated out
            data_o = {data_i[1:0], data_i[DATA_W-1:2]};
`ifdef SHIFTER_CARRY_EN
            carry_o = data_i[1];
`endif
         end
         default: begin
            data_o = data_i;
         end
      endcase
   end

endmodule

// File: rtl/val2_shift_sequencer.sv
// val2_shift_sequencer: computes ARM operand-2 one shift step per clock
// with a start/done handshake. Optional macro SHIFTER_CARRY_EN adds the
// c_in input and shifter_carry output plus the carry register.
module val2_shift_sequencer
   import arm_shift_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              flush,
   input  logic              imm,
   input  logic              is_mem_cmd,
   input  logic [SHOP_W-1:0] shift_operand,
   input  logic [DATA_W-1:0] val_rm,
`ifdef SHIFTER_CARRY_EN
   input  logic              c_in,
   output logic              shifter_carry,
`endif
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] val2
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   op_e               op_q, op_d;
   logic [4:0]        count_q, count_d;
   logic [DATA_W-1:0] val2_q, val2_d;
`ifdef SHIFTER_CARRY_EN
   logic              carry_q, carry_d;
   logic              step_carry;
`endif

   logic [DATA_W-1:0] step_data;
   logic [DATA_W-1:0] ld_data;
   op_e               ld_op;
   logic [4:0]        ld_count;

   shift_step u_step (
      .data_i  (data_q),
      .op_i    (op_q),
`ifdef SHIFTER_CARRY_EN
      .carry_i (carry_q),
      .carry_o (step_carry),
`endif
      .data_o  (step_data)
   );

   // Decode the operand form presented with start (MEM beats imm)
   always_comb begin
      ld_data  = val_rm;
      ld_op    = op_e'({1'b0, shift_operand[6:5]});
      ld_count = shift_operand[11:7];
      if (is_mem_cmd) begin
         ld_data  = {20'b0, shift_operand};
         ld_op    = OP_LSL;
         ld_count = 5'd0;
      end else if (imm) begin
         ld_data  = {24'b0, shift_operand[7:0]};
         ld_op    = OP_ROR2;
         ld_count = {1'b0, shift_operand[11:8]};
      end
   end

   // Next-state: accept/reload, step while counting down, flush abort
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      op_d    = op_q;
      count_d = count_q;
      val2_d  = val2_q;
`ifdef SHIFTER_CARRY_EN
      carry_d = carry_q;
`endif
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               state_d = IDLE;
               if (start) begin
                  data_d  = ld_data;
                  op_d    = ld_op;
                  count_d = ld_count;
                  if (ld_count == 5'd0) begin
                     // Nothing to shift: result is the loaded value itself
                     state_d = DONE;
                     val2_d  = ld_data;
`ifdef SHIFTER_CARRY_EN
                     carry_d = c_in;
`endif
                  end else begin
                     state_d = SHIFT;
`ifdef SHIFTER_CARRY_EN
                     carry_d = c_in;
`endif
                  end
               end
            end
            SHIFT: begin
               data_d  = step_data;
               count_d = count_q - 5'd1;
               if (count_q == 5'd1) begin
                  state_d = DONE;
                  val2_d  = step_data;
`ifdef SHIFTER_CARRY_EN
                  carry_d = step_carry;
`endif
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers, cleared by async reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         op_q    <= OP_LSL;
         count_q <= '0;
         val2_q  <= '0;
`ifdef SHIFTER_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         op_q    <= op_d;
         count_q <= count_d;
         val2_q  <= val2_d;
`ifdef SHIFTER_CARRY_EN
         carry_q <= carry_d;
`endif
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign val2 = val2_q;
`ifdef SHIFTER_CARRY_EN
   // Carry output changes only together with val2 (on entering DONE)
   logic carry_out_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) carry_out_q <= 1'b0;
      else if (!flush && state_d == DONE && state_q != DONE) carry_out_q <= carry_d;
      else if (!flush && state_d == DONE && start) carry_out_q <= carry_d;
   end
   assign shifter_carry = carry_out_q;
`endif

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Directed self-checking bench for val2_shift_sequencer. Define
// SHIFTER_CARRY_EN to also check the carry output.
`timescale 1ns/1ps
module tb_val2_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, flush, imm, is_mem_cmd;
   logic [11:0] shift_operand;
   logic [31:0] val_rm;
   logic        busy, done;
   logic [31:0] val2;
`ifdef SHIFTER_CARRY_EN
   logic        c_in;
   logic        shifter_carry;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int cyc, nbusy, both;

   val2_shift_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .flush         (flush),
      .imm           (imm),
      .is_mem_cmd    (is_mem_cmd),
      .shift_operand (shift_operand),
      .val_rm        (val_rm),
`ifdef SHIFTER_CARRY_EN
      .c_in          (c_in),
      .shifter_carry (shifter_carry),
`endif
      .busy          (busy),
      .done          (done),
      .val2          (val2)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single cycle; returns just after accept edge
   task automatic issue(input logic mem, input logic im, input logic [11:0] so,
                        input logic [31:0] rm);
      is_mem_cmd = mem; imm = im; shift_operand = so; val_rm = rm;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Wait for done with a bound; optionally pulse a stray start at inject_at
   task automatic wait_done(input int inject_at, output int c, output int nb, output int bh);
      c = 1; nb = 0; bh = 0;
      while (!done && c < 40) begin
         if (busy) nb++;
         if (c == inject_at) begin
            start = 1'b1; is_mem_cmd = 1'b1; shift_operand = 12'h123;
         end
         step();
         start = 1'b0; is_mem_cmd = 1'b0;
         if (busy && done) bh++;
         c++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; imm = 1'b0; is_mem_cmd = 1'b0;
      shift_operand = 12'h000; val_rm = 32'h0;
`ifdef SHIFTER_CARRY_EN
      c_in = 1'b1;
`endif
      step(); step();
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_done", {31'b0, done}, 32'd0);
      check_eq("rst_val2", val2, 32'h0);
`ifdef SHIFTER_CARRY_EN
      check_eq("rst_carry", {31'b0, shifter_carry}, 32'd0);
`endif
      rst = 1'b0;
      step();

      // MEM form: done immediately, never busy
      issue(1'b1, 1'b0, 12'hABC, 32'hDEADBEEF);
      wait_done(-1, cyc, nbusy, both);
      check_eq("mem_lat", cyc, 1);
      check_eq("mem_busy", nbusy, 0);
      check_eq("mem_val2", val2, 32'h00000ABC);
`ifdef SHIFTER_CARRY_EN
      check_eq("mem_carry", {31'b0, shifter_carry}, 32'd1);
      c_in = 1'b0;
`endif
      step();
      check_eq("mem_done_pulse", {31'b0, done}, 32'd0);

      // MEM has priority over imm
      issue(1'b1, 1'b1, 12'h4FF, 32'h0);
      wait_done(-1, cyc, nbusy, both);
      check_eq("prio_lat", cyc, 1);
      check_eq("prio_val2", val2, 32'h000004FF);
      step();

      // Immediate 0xFF rotated right by 8
      issue(1'b0, 1'b1, 12'h4FF, 32'h0);
      wait_done(-1, cyc, nbusy, both);
      check_eq("imm_lat", cyc, 5);
      check_eq("imm_busy", nbusy, 4);
      check_eq("imm_val2", val2, 32'hFF000000);
`ifdef SHIFTER_CARRY_EN
      check_eq("imm_carry", {31'b0, shifter_carry}, 32'd1);
`endif
      step();

      // ASR by 4 of negative value
      issue(1'b0, 1'b0, 12'h240, 32'h80000000);
      wait_done(-1, cyc, nbusy, both);
      check_eq("asr_lat", cyc, 5);
      check_eq("asr_val2", val2, 32'hF8000000);
`ifdef SHIFTER_CARRY_EN
      check_eq("asr_carry", {31'b0, shifter_carry}, 32'd0);
`endif
      step();

      // LSR by 2 of 6 -> 1, carry = 1
      issue(1'b0, 1'b0, 12'h120, 32'h00000006);
      wait_done(-1, cyc, nbusy, both);
      check_eq("lsr_lat", cyc, 3);
      check_eq("lsr_val2", val2, 32'h00000001);
`ifdef SHIFTER_CARRY_EN
      check_eq("lsr_carry", {31'b0, shifter_carry}, 32'd1);
`endif
      step();

      // LSL by 2 of 3 -> 0xC
      issue(1'b0, 1'b0, 12'h100, 32'h00000003);
      wait_done(-1, cyc, nbusy, both);
      check_eq("lsl_val2", val2, 32'h0000000C);
      step();

      // ROR by 31 with a stray start during busy
      issue(1'b0, 1'b0, 12'hFE0, 32'h00000001);
      wait_done(6, cyc, nbusy, both);
      check_eq("ror_lat", cyc, 32);
      check_eq("ror_busy", nbusy, 31);
      check_eq("ror_excl", both, 0);
      check_eq("ror_val2", val2, 32'h00000002);

      // Back-to-back: start in the DONE cycle
      issue(1'b1, 1'b0, 12'h055, 32'h0);
      check_eq("b2b_done", {31'b0, done}, 32'd1);
      check_eq("b2b_val2", val2, 32'h00000055);
      step();
      check_eq("b2b_idle", {30'b0, busy, done}, 32'd0);

      // Flush in SHIFT: abort, no done, val2 kept
      issue(1'b0, 1'b0, 12'h500, 32'h00000001);
      step(); step();
      check_eq("fl_busy", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_eq("fl_idle", {30'b0, busy, done}, 32'd0);
      repeat (12) step();
      check_eq("fl_nodone", {30'b0, busy, done}, 32'd0);
      check_eq("fl_val2", val2, 32'h00000055);

      // flush beats start
      flush = 1'b1;
      issue(1'b1, 1'b0, 12'h777, 32'h0);
      flush = 1'b0;
      check_eq("fl_start", {30'b0, busy, done}, 32'd0);
      check_eq("fl_start_val2", val2, 32'h00000055);

      // Async reset mid-SHIFT
      issue(1'b0, 1'b0, 12'hFE0, 32'h00000001);
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      check_eq("arst_busy", {31'b0, busy}, 32'd0);
      check_eq("arst_val2", val2, 32'h0);
      step();
      rst = 1'b0;
      repeat (35) begin
         step();
         if (done || busy) check_eq("arst_quiet", {30'b0, busy, done}, 32'd0);
      end
      check_eq("arst_end", {30'b0, busy, done}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
